// File: rtl/rv32i_lsu_sequencer.sv
// Load/store sequencer between execute and a synchronous RAM data port: lane steering, read merge/extend, misaligned split.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned (split-qualifying) requests are rejected with rsp_err instead of split.
module rv32i_lsu_sequencer #(
  parameter int XLEN   = 32,
  parameter int RAM_AW = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_width,
  input  logic              req_sign,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [XLEN-1:0]   ram_wdata,
  input  logic [XLEN-1:0]   ram_rdata
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_MISALIGN = 1'b1;
`else
  localparam bit TRAP_MISALIGN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RSP} state_t;

  state_t          state;
  logic            op_we;
  logic [1:0]      op_width;
  logic            op_sign;
  logic [1:0]      op_off;
  logic            op_split;
  logic            op_err;
  logic [7:0]      op_m8;
  logic [XLEN-1:0] op_wdata;
  logic [XLEN-1:0] lo_reg;

  logic [1:0]      in_off;
  logic            in_split;
  logic            in_err;
  logic [7:0]      in_m8;

  always_comb begin
    in_off   = req_addr[1:0];
    in_split = ((req_width == 2'b01) && (in_off == 2'd3)) ||
               ((req_width == 2'b10) && (in_off != 2'd0));
    in_err   = (req_width == 2'b11) || (TRAP_MISALIGN && in_split);
    case (req_width)
      2'b00:   in_m8 = 8'b0000_0001 << in_off;
      2'b01:   in_m8 = 8'b0000_0011 << in_off;
      default: in_m8 = 8'b0000_1111 << in_off;
    endcase
  end

  // In RSP the live RAM word is the high word of a split access, or the only word otherwise.
  logic [XLEN-1:0] lo_word;
  logic [XLEN-1:0] hi_word;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_val;

  always_comb begin
    lo_word = op_split ? lo_reg : ram_rdata;
    hi_word = op_split ? ram_rdata : '0;
    shifted = XLEN'({hi_word, lo_word} >> {op_off, 3'b000});
    case (op_width)
      2'b00:   load_val = {{24{op_sign & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{op_sign & shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_be    <= 4'b0000;
      ram_wdata <= '0;
      op_we     <= 1'b0;
      op_width  <= 2'b00;
      op_sign   <= 1'b0;
      op_off    <= 2'd0;
      op_split  <= 1'b0;
      op_err    <= 1'b0;
      op_m8     <= 8'h00;
      op_wdata  <= '0;
      lo_reg    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            op_we     <= req_we;
            op_width  <= req_width;
            op_sign   <= req_sign;
            op_off    <= in_off;
            op_split  <= in_split;
            op_err    <= in_err;
            op_m8     <= in_m8;
            op_wdata  <= req_wdata;
            if (in_err) begin
              state <= RSP;
            end else begin
              state     <= ACC0;
              ram_addr  <= req_addr[RAM_AW+1:2];
              ram_we    <= req_we;
              ram_be    <= in_m8[3:0];
              ram_wdata <= req_wdata << {in_off, 3'b000};
            end
          end
        end
        ACC0: begin
          if (op_split) begin
            state     <= ACC1;
            ram_addr  <= ram_addr + 1'b1;
            ram_be    <= op_m8[7:4];
            ram_wdata <= op_wdata >> (6'd32 - {1'b0, op_off, 3'b000});
          end else begin
            state  <= RSP;
            ram_we <= 1'b0;
            ram_be <= 4'b0000;
          end
        end
        ACC1: begin
          lo_reg <= ram_rdata;
          ram_we <= 1'b0;
          ram_be <= 4'b0000;
          state  <= RSP;
        end
        default: begin
          rsp_valid <= 1'b1;
          rsp_err   <= op_err;
          rsp_rdata <= (op_err || op_we) ? '0 : load_val;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
